cam_rgb565_capture: RTL and testbench
=====================================

Name: cam_rgb565_capture

Overview:
- Camera-side capture stage between the OV2640 parallel port and the frame buffer's vin0 write channel.
- Converts the 8-bit-per-clock byte stream (PIXDATA[9:2], HREF, VSYNC) into 16-bit RGB565 pixel words with a one-cycle write strobe.
- Locks onto frame boundaries so the first partial frame after reset is discarded, crops to the frame-buffer resolution, and reports frame/line statistics and framing errors.
- Runs entirely in the camera pixel-clock domain.

Parameters:
- H_RES, 640, active pixels per line forwarded downstream; pixels with x >= H_RES are dropped.
- V_RES, 480, active lines per frame forwarded; lines with y >= V_RES are dropped.
- BYTE_SWAP, 0, 0: first byte of a pair is the high byte [15:8]; 1: first byte is the low byte [7:0].
- IN_W, 10, width of the raw camera data bus; bits [IN_W-1:IN_W-8] are used.

Ports:
- I_clk  in  1  camera pixel clock (PIXCLK).
- I_rst  in  1  asynchronous reset, active-high.
- I_vsync  in  1  camera VSYNC; high = vertical blank.
- I_href  in  1  camera HREF; high = valid bytes.
- I_data  in  IN_W  camera data bus.
- I_err_clr  in  1  synchronous pulse; clears O_err.
- O_vs_n  out  1  frame sync to the frame buffer; low while in vertical blank.
- O_de  out  1  pixel write strobe; high for one cycle per output pixel.
- O_data  out  16  RGB565 pixel, valid when O_de = 1.
- O_locked  out  1  high once the first frame start has been seen.
- O_frame_cnt  out  8  completed frames; wraps 255 -> 0.
- O_last_line_px  out  12  pixel count of the most recent line, uncropped.
- O_last_frame_ln  out  11  line count of the most recent frame, uncropped.
- O_err  out  1  sticky framing error.

Behaviour:
- Reset values:
  - O_vs_n = 1, O_de = 0, O_data = 0, O_locked = 0, O_frame_cnt = 0, O_last_line_px = 0, O_last_frame_ln = 0, O_err = 0.
  - FSM = IDLE; byte phase = 0; x = 0, y = 0.
- Input stage: I_vsync, I_href and I_data[IN_W-1:IN_W-8] are registered once (stage 1). All logic below works on the stage-1 values.
- FSM states:
  - IDLE: wait for vsync = 1, then go to BLANK. O_vs_n is held at 1.
  - BLANK: wait for vsync 1->0, then go to ACTIVE. On that falling edge: O_locked <= 1, y <= 0.
  - ACTIVE: capture lines. On vsync 0->1, go to BLANK, increment O_frame_cnt, O_last_frame_ln <= line count, and set O_err if line count != V_RES.
- O_vs_n: equals ~vsync(stage 1), registered (2 clocks behind I_vsync) in BLANK and ACTIVE; held at 1 in IDLE.
- Byte pairing (ACTIVE and href = 1):
  - Phase toggles every clock; phase 0 captures the first byte, phase 1 captures the second byte and forms the pixel.
  - Phase resets to 0 whenever href = 0.
  - O_de pulses for one cycle, 2 clocks after I_data carries the second byte, only if x < H_RES and y < V_RES; O_data is updated on the same edge.
  - O_data holds its value when O_de = 0.
  - x increments per pixel and saturates at 4095.
- Line end (href 1->0 in ACTIVE):
  - O_last_line_px <= x; y increments and saturates at 2047; x <= 0.
  - O_err <= 1 if the byte phase is 1 (odd byte count) or if x != H_RES while y < V_RES.
- href high in BLANK or IDLE: bytes are ignored and no O_de is issued.
- A vsync rise while href = 1: the partial line is abandoned, O_err <= 1, and the state goes to BLANK.
- O_err clears on I_err_clr. If a new error condition occurs in the same cycle as I_err_clr, the set wins.
- Throughput: at most one pixel every 2 clocks; no backpressure (the downstream FIFO-full flag is not used here).
- Reset mid-frame: all state returns to reset values, and the block relocks only on the next vsync rise followed by its fall.

Decomposition:
- Shared package video_cfg_pkg:
  - Constants: RGB565_W = 16, CAM_BYTE_W = 8, default resolution constants 640/480.
  - FSM state typedef {IDLE, BLANK, ACTIVE}.
- Natural sub-module: cam_byte_pair. It holds the stage-1 registers, the phase toggle, byte-swap selection and pixel-valid generation.
- The top level keeps the FSM, counters, cropping and status logic.

Test Plan:
- Reset, then 2 frames of 640x480 (each line 1280 bytes, 0x12/0x34 alternating, BYTE_SWAP = 0) -> no O_de before the first vsync fall; frame 1 gives 307200 O_de pulses with O_data = 0x1234; O_frame_cnt = 1 at the end of frame 1; O_err = 0.
- Start stimulus mid-frame (VSYNC low, HREF toggling) -> zero O_de and O_locked = 0 until vsync goes 1 then 0; O_vs_n stays 1 in IDLE.
- 800x600 input with H_RES = 640, V_RES = 480 -> exactly 640 O_de per line for lines 0..479, none for lines 480..599; O_last_line_px = 800, O_last_frame_ln = 600; O_err = 1 due to line count.
- One line of 1279 bytes -> O_err = 1 after that line's HREF fall; a following I_err_clr -> O_err = 0; the next line aligns to phase 0 with a correct pixel value.
- BYTE_SWAP = 1 with bytes 0xAB then 0xCD -> O_data = 0xCDAB, and O_de rises 2 clocks after the 0xCD byte.
- 256 complete frames -> O_frame_cnt wraps to 0. Asserting I_rst mid-line -> all outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/video_cfg_pkg.sv
// video_cfg_pkg: shared video constants and capture FSM state type
package video_cfg_pkg;
   localparam int RGB565_W   = 16;
   localparam int CAM_BYTE_W = 8;
   localparam int DEF_H_RES  = 640;
   localparam int DEF_V_RES  = 480;
   typedef enum logic [1:0] {IDLE, BLANK, ACTIVE} cap_state_e;
endpackage

// File: rtl/cam_byte_pair.sv
// cam_byte_pair: input registers, sync edge detection and byte-to-RGB565 pairing
module cam_byte_pair import video_cfg_pkg::*; #(
   parameter int BYTE_SWAP = 0,
   parameter int IN_W      = 10
) (
   input  logic                I_clk,
   input  logic                I_rst,
   input  logic                I_vsync,
   input  logic                I_href,
   input  logic [IN_W-1:0]     I_data,
   input  logic                I_active,
   output logic                O_vs,
   output logic                O_vs_rise,
   output logic                O_vs_fall,
   output logic                O_href,
   output logic                O_href_fall,
   output logic                O_phase,
   output logic                O_pix_vld,
   output logic [RGB565_W-1:0] O_pix
);
   logic                  vs_q, vs_prev_q, hr_q, hr_prev_q, phase_q, phase_d;
   logic [CAM_BYTE_W-1:0] d_q, b0_q;
   logic                  unused_ok;
   assign unused_ok = &{1'b0, I_data};
   // phase only advances while capturing; any href gap realigns to the first byte
   assign phase_d = I_active & hr_q & ~phase_q;
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         vs_q      <= 1'b0;
         vs_prev_q <= 1'b0;
         hr_q      <= 1'b0;
         hr_prev_q <= 1'b0;
         phase_q   <= 1'b0;
         d_q       <= '0;
         b0_q      <= '0;
      end else begin
         vs_q      <= I_vsync;
         vs_prev_q <= vs_q;
         hr_q      <= I_href;
         hr_prev_q <= hr_q;
         phase_q   <= phase_d;
         d_q       <= I_data[IN_W-1 -: CAM_BYTE_W];
         if (!phase_q) b0_q <= d_q;
      end
   end
   assign O_vs        = vs_q;
   assign O_vs_rise   = vs_q & ~vs_prev_q;
   assign O_vs_fall   = ~vs_q & vs_prev_q;
   assign O_href      = hr_q;
   assign O_href_fall = ~hr_q & hr_prev_q;
   assign O_phase     = phase_q;
   assign O_pix_vld   = I_active & hr_q & phase_q;
   assign O_pix       = (BYTE_SWAP != 0) ? {d_q, b0_q} : {b0_q, d_q};
endmodule

// File: rtl/cam_rgb565_capture.sv
// cam_rgb565_capture: OV2640 byte stream to cropped RGB565 pixels with frame lock and stats
module cam_rgb565_capture import video_cfg_pkg::*; #(
   parameter int H_RES     = DEF_H_RES,
   parameter int V_RES     = DEF_V_RES,
   parameter int BYTE_SWAP = 0,
   parameter int IN_W      = 10
) (
   input  logic                I_clk,
   input  logic                I_rst,
   input  logic                I_vsync,
   input  logic                I_href,
   input  logic [IN_W-1:0]     I_data,
   input  logic                I_err_clr,
   output logic                O_vs_n,
   output logic                O_de,
   output logic [RGB565_W-1:0] O_data,
   output logic                O_locked,
   output logic [7:0]          O_frame_cnt,
   output logic [11:0]         O_last_line_px,
   output logic [10:0]         O_last_frame_ln,
   output logic                O_err
);
   localparam logic [11:0] H_LIM = 12'(H_RES);
   localparam logic [10:0] V_LIM = 11'(V_RES);
   cap_state_e          state_q, state_d;
   logic                vs, vs_rise, vs_fall, href, href_fall, phase, pix_vld, err_set;
   logic [RGB565_W-1:0] pix, data_q, data_d;
   logic                vs_n_q, vs_n_d, de_q, de_d, locked_q, locked_d, err_q, err_d;
   logic [7:0]          fcnt_q, fcnt_d;
   logic [11:0]         x_q, x_d, lpx_q, lpx_d;
   logic [10:0]         y_q, y_d, lln_q, lln_d;
   cam_byte_pair #(.BYTE_SWAP(BYTE_SWAP), .IN_W(IN_W)) u_pair (
      .I_clk(I_clk), .I_rst(I_rst), .I_vsync(I_vsync), .I_href(I_href), .I_data(I_data),
      .I_active(state_q == ACTIVE), .O_vs(vs), .O_vs_rise(vs_rise), .O_vs_fall(vs_fall),
      .O_href(href), .O_href_fall(href_fall), .O_phase(phase), .O_pix_vld(pix_vld), .O_pix(pix)
   );
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      lpx_d    = lpx_q;
      lln_d    = lln_q;
      fcnt_d   = fcnt_q;
      locked_d = locked_q;
      data_d   = data_q;
      de_d     = 1'b0;
      err_set  = 1'b0;
      case (state_q)
         IDLE:  state_d = vs ? BLANK : IDLE;
         BLANK: if (vs_fall) begin
            state_d  = ACTIVE;
            locked_d = 1'b1;
            x_d      = '0;
            y_d      = '0;
         end
         ACTIVE: if (vs_rise) begin
            // a vsync rise with href still high abandons the partial line
            state_d = BLANK;
            fcnt_d  = fcnt_q + 8'd1;
            lln_d   = y_q;
            x_d     = '0;
            err_set = (y_q != V_LIM) | href;
         end else if (href_fall) begin
            lpx_d   = x_q;
            x_d     = '0;
            y_d     = (&y_q) ? y_q : y_q + 11'd1;
            err_set = phase | ((x_q != H_LIM) & (y_q < V_LIM));
         end else if (pix_vld) begin
            x_d    = (&x_q) ? x_q : x_q + 12'd1;
            de_d   = (x_q < H_LIM) & (y_q < V_LIM);
            data_d = de_d ? pix : data_q;
         end
         default: state_d = IDLE;
      endcase
      vs_n_d = (state_d == IDLE) | ~vs;
      err_d  = err_set | (err_q & ~I_err_clr);
   end
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         lpx_q    <= '0;
         lln_q    <= '0;
         fcnt_q   <= '0;
         locked_q <= 1'b0;
         data_q   <= '0;
         de_q     <= 1'b0;
         vs_n_q   <= 1'b1;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         lpx_q    <= lpx_d;
         lln_q    <= lln_d;
         fcnt_q   <= fcnt_d;
         locked_q <= locked_d;
         data_q   <= data_d;
         de_q     <= de_d;
         vs_n_q   <= vs_n_d;
         err_q    <= err_d;
      end
   end
   assign O_vs_n          = vs_n_q;
   assign O_de            = de_q;
   assign O_data          = data_q;
   assign O_locked        = locked_q;
   assign O_frame_cnt     = fcnt_q;
   assign O_last_line_px  = lpx_q;
   assign O_last_frame_ln = lln_q;
   assign O_err           = err_q;
endmodule

// File: tb/tb_cam_rgb565_capture.sv
// tb_cam_rgb565_capture: randomized frame stimulus checked against a line/frame level model
module tb_cam_rgb565_capture;
   localparam int H = 8;
   localparam int V = 4;
   logic I_clk = 1'b0, I_rst = 1'b1, I_vsync = 1'b0, I_href = 1'b0, I_err_clr = 1'b0;
   logic [9:0] I_data = '0;
   logic vs_n_a, de_a, locked_a, err_a, vs_n_b, de_b, locked_b, err_b;
   logic [15:0] data_a, data_b;
   logic [7:0] fcnt_a, fcnt_b;
   logic [11:0] lpx_a, lpx_b;
   logic [10:0] lln_a, lln_b;
   int n_cmp = 0, n_err = 0, de_cnt = 0, exp_cnt = 0;
   logic [15:0] q[$];
   logic [7:0] lb[$];
   bit m_seen = 0, m_active = 0, m_locked = 0, m_err = 0;
   int m_y = 0, m_last_px = 0, m_last_ln = 0;
   logic [7:0] m_fcnt = 0;

   cam_rgb565_capture #(.H_RES(H), .V_RES(V), .BYTE_SWAP(0), .IN_W(10)) dut_a (
      .I_clk(I_clk), .I_rst(I_rst), .I_vsync(I_vsync), .I_href(I_href), .I_data(I_data),
      .I_err_clr(I_err_clr), .O_vs_n(vs_n_a), .O_de(de_a), .O_data(data_a), .O_locked(locked_a),
      .O_frame_cnt(fcnt_a), .O_last_line_px(lpx_a), .O_last_frame_ln(lln_a), .O_err(err_a));
   cam_rgb565_capture #(.H_RES(H), .V_RES(V), .BYTE_SWAP(1), .IN_W(10)) dut_b (
      .I_clk(I_clk), .I_rst(I_rst), .I_vsync(I_vsync), .I_href(I_href), .I_data(I_data),
      .I_err_clr(I_err_clr), .O_vs_n(vs_n_b), .O_de(de_b), .O_data(data_b), .O_locked(locked_b),
      .O_frame_cnt(fcnt_b), .O_last_line_px(lpx_b), .O_last_frame_ln(lln_b), .O_err(err_b));

   always #5 I_clk = ~I_clk;

   always @(negedge I_clk) if (!I_rst) begin
      n_cmp++;
      if (de_b !== de_a) begin n_err++; $display("FAIL de_sync: swap de=%b plain de=%b", de_b, de_a); end
      if (de_a === 1'b1) begin
         de_cnt++;
         n_cmp++;
         if (q.size() == 0) begin
            n_err++; $display("FAIL unexpected_de: got data %h, no pixel expected", data_a);
         end else begin
            logic [15:0] e;
            e = q.pop_front();
            if (data_a !== e) begin n_err++; $display("FAIL pixel: got %h want %h", data_a, e); end
            n_cmp++;
            if (data_b !== {e[7:0], e[15:8]}) begin
               n_err++; $display("FAIL pixel_swap: got %h want %h", data_b, {e[7:0], e[15:8]});
            end
         end
      end
   end

   task automatic tick;
      @(posedge I_clk); #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      I_href = 1'b1;
      I_data = {b, 2'($urandom)};
      lb.push_back(b);
      if (m_active && lb.size() % 2 == 0 && lb.size() / 2 - 1 < H && m_y < V) begin
         q.push_back({lb[lb.size()-2], b});
         exp_cnt++;
      end
   endtask

   task automatic end_line;
      int n;
      I_href = 1'b0;
      n = lb.size();
      if (m_active) begin
         m_last_px = (n / 2 > 4095) ? 4095 : n / 2;
         if (n % 2 == 1 || (m_y < V && n / 2 != H)) m_err = 1;
         m_y = (m_y < 2047) ? m_y + 1 : 2047;
      end
      lb.delete();
   endtask

   task automatic set_vs(input bit v);
      if (v && !I_vsync) begin
         m_seen = 1;
         if (m_active) begin
            m_fcnt++;
            m_last_ln = m_y;
            if (m_y != V || I_href) m_err = 1;
            m_active = 0;
         end
      end else if (!v && I_vsync && m_seen) begin
         m_active = 1; m_locked = 1; m_y = 0;
      end
      I_vsync = v;
   endtask

   task automatic send_line(input int n, input bit fixed);
      for (int i = 0; i < n; i++) begin
         push_byte(fixed ? ((i % 2 == 1) ? 8'h34 : 8'h12) : 8'($urandom));
         tick();
      end
      end_line();
      repeat (3) tick();
   endtask

   task automatic clear_err;
      I_err_clr = 1'b1; tick(); I_err_clr = 1'b0; m_err = 0; tick();
   endtask

   task automatic frame_open;
      if (!I_vsync) set_vs(1);
      repeat (4) tick();
      n_cmp++;
      if (vs_n_a !== 1'b0) begin n_err++; $display("FAIL vs_n_blank: got %b want 0", vs_n_a); end
      set_vs(0);
      repeat (3) tick();
      n_cmp++;
      if (locked_a !== 1'b1) begin n_err++; $display("FAIL locked: got %b want 1", locked_a); end
      de_cnt = 0; exp_cnt = 0;
   endtask

   task automatic frame_close;
      set_vs(1);
      repeat (5) tick();
      n_cmp += 7;
      if (fcnt_a !== m_fcnt) begin n_err++; $display("FAIL frame_cnt: got %0d want %0d", fcnt_a, m_fcnt); end
      if (fcnt_b !== m_fcnt) begin n_err++; $display("FAIL frame_cnt_b: got %0d want %0d", fcnt_b, m_fcnt); end
      if (lln_a !== 11'(m_last_ln)) begin n_err++; $display("FAIL last_frame_ln: got %0d want %0d", lln_a, m_last_ln); end
      if (lpx_a !== 12'(m_last_px)) begin n_err++; $display("FAIL last_line_px: got %0d want %0d", lpx_a, m_last_px); end
      if (err_a !== m_err) begin n_err++; $display("FAIL err: got %b want %b", err_a, m_err); end
      if (q.size() != 0) begin n_err++; $display("FAIL missing_px: got %0d pending want 0", q.size()); end
      if (de_cnt != exp_cnt) begin n_err++; $display("FAIL de_count: got %0d want %0d", de_cnt, exp_cnt); end
   endtask

   task automatic test_reset;
      repeat (3) tick();
      n_cmp += 8;
      if (vs_n_a !== 1'b1) begin n_err++; $display("FAIL rst_vs_n: got %b want 1", vs_n_a); end
      if (de_a !== 1'b0) begin n_err++; $display("FAIL rst_de: got %b want 0", de_a); end
      if (data_a !== 16'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", data_a); end
      if (locked_a !== 1'b0) begin n_err++; $display("FAIL rst_locked: got %b want 0", locked_a); end
      if (fcnt_a !== 8'h0) begin n_err++; $display("FAIL rst_fcnt: got %0d want 0", fcnt_a); end
      if (lpx_a !== 12'h0) begin n_err++; $display("FAIL rst_lpx: got %0d want 0", lpx_a); end
      if (lln_a !== 11'h0) begin n_err++; $display("FAIL rst_lln: got %0d want 0", lln_a); end
      if (err_a !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err_a); end
      I_rst = 1'b0;
      tick();
   endtask

   task automatic test_unlocked_start;
      for (int l = 0; l < 3; l++) begin
         send_line(2 * H, 0);
         n_cmp += 2;
         if (locked_a !== 1'b0) begin n_err++; $display("FAIL idle_locked: got %b want 0", locked_a); end
         if (vs_n_a !== 1'b1) begin n_err++; $display("FAIL idle_vs_n: got %b want 1", vs_n_a); end
      end
   endtask

   task automatic test_frames;
      frame_open();
      for (int l = 0; l < V; l++) send_line(2 * H, 1);
      frame_close();
      n_cmp += 3;
      if (de_cnt != H * V) begin n_err++; $display("FAIL frame1_de: got %0d want %0d", de_cnt, H * V); end
      if (fcnt_a !== 8'd1) begin n_err++; $display("FAIL frame1_cnt: got %0d want 1", fcnt_a); end
      if (err_a !== 1'b0) begin n_err++; $display("FAIL frame1_err: got %b want 0", err_a); end
      frame_open();
      for (int l = 0; l < V; l++) send_line(2 * H, 0);
      frame_close();
   endtask

   task automatic test_crop;
      frame_open();
      for (int l = 0; l < V + 3; l++) send_line(2 * (H + 3), 0);
      frame_close();
      n_cmp += 4;
      if (de_cnt != H * V) begin n_err++; $display("FAIL crop_de: got %0d want %0d", de_cnt, H * V); end
      if (lpx_a !== 12'(H + 3)) begin n_err++; $display("FAIL crop_lpx: got %0d want %0d", lpx_a, H + 3); end
      if (lln_a !== 11'(V + 3)) begin n_err++; $display("FAIL crop_lln: got %0d want %0d", lln_a, V + 3); end
      if (err_a !== 1'b1) begin n_err++; $display("FAIL crop_err: got %b want 1", err_a); end
      clear_err();
      n_cmp++;
      if (err_a !== 1'b0) begin n_err++; $display("FAIL crop_clr: got %b want 0", err_a); end
   endtask

   task automatic test_odd_line;
      frame_open();
      send_line(2 * H, 0);
      send_line(2 * H - 1, 0);
      n_cmp++;
      if (err_a !== 1'b1) begin n_err++; $display("FAIL odd_err: got %b want 1", err_a); end
      clear_err();
      n_cmp++;
      if (err_a !== 1'b0) begin n_err++; $display("FAIL odd_clr: got %b want 0", err_a); end
      for (int l = 2; l < V; l++) send_line(2 * H, 0);
      frame_close();
   endtask

   task automatic test_swap;
      frame_open();
      push_byte(8'hAB); tick();
      push_byte(8'hCD); tick();
      n_cmp++;
      if (de_b !== 1'b0) begin n_err++; $display("FAIL swap_early: de got %b want 0", de_b); end
      end_line(); tick();
      n_cmp += 3;
      if (de_b !== 1'b1) begin n_err++; $display("FAIL swap_de: got %b want 1", de_b); end
      if (data_b !== 16'hCDAB) begin n_err++; $display("FAIL swap_data: got %h want cdab", data_b); end
      if (data_a !== 16'hABCD) begin n_err++; $display("FAIL noswap_data: got %h want abcd", data_a); end
      repeat (3) tick();
      frame_close();
      clear_err();
   endtask

   task automatic test_reset_midline;
      frame_open();
      send_line(2 * H, 0);
      for (int i = 0; i < 5; i++) begin push_byte(8'($urandom)); tick(); end
      #2 I_rst = 1'b1;
      #1;
      n_cmp += 8;
      if (vs_n_a !== 1'b1) begin n_err++; $display("FAIL mrst_vs_n: got %b want 1", vs_n_a); end
      if (de_a !== 1'b0) begin n_err++; $display("FAIL mrst_de: got %b want 0", de_a); end
      if (data_a !== 16'h0) begin n_err++; $display("FAIL mrst_data: got %h want 0", data_a); end
      if (locked_a !== 1'b0) begin n_err++; $display("FAIL mrst_locked: got %b want 0", locked_a); end
      if (fcnt_a !== 8'h0) begin n_err++; $display("FAIL mrst_fcnt: got %0d want 0", fcnt_a); end
      if (lpx_a !== 12'h0) begin n_err++; $display("FAIL mrst_lpx: got %0d want 0", lpx_a); end
      if (lln_a !== 11'h0) begin n_err++; $display("FAIL mrst_lln: got %0d want 0", lln_a); end
      if (err_a !== 1'b0) begin n_err++; $display("FAIL mrst_err: got %b want 0", err_a); end
      q.delete(); lb.delete();
      m_seen = 0; m_active = 0; m_locked = 0; m_err = 0;
      m_y = 0; m_last_px = 0; m_last_ln = 0; m_fcnt = 0;
      I_href = 1'b0;
      tick(); tick();
      I_rst = 1'b0;
      tick();
      test_unlocked_start();
   endtask

   task automatic test_wrap;
      for (int f = 0; f < 256; f++) begin
         frame_open();
         send_line(2, 0);
         frame_close();
      end
      n_cmp += 2;
      if (fcnt_a !== 8'd0) begin n_err++; $display("FAIL wrap_cnt: got %0d want 0", fcnt_a); end
      if (locked_a !== 1'b1) begin n_err++; $display("FAIL wrap_locked: got %b want 1", locked_a); end
   endtask

   initial begin
      test_reset();
      test_unlocked_start();
      test_frames();
      test_crop();
      test_odd_line();
      test_swap();
      test_reset_midline();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
